// File: rtl/aes_composite_enc_unrolled.sv
// Iterative AES-128 encryptor with UNROLL rounds per clock, ECB and CTR modes.
// Handshake: Krdy/IVrdy/Drdy are single-cycle strobes taken only while BSY=0 and EN=1; Kvld/Dvld are one-cycle result pulses.
module aes_composite_enc_unrolled #(
    parameter int UNROLL = 1
) (
    input  logic         CLK,
    input  logic         RSTn,
    input  logic         EN,
    input  logic [127:0] Kin,
    input  logic         Krdy,
    input  logic [127:0] Din,
    input  logic         Drdy,
    input  logic         Mode,
    input  logic [127:0] IVin,
    input  logic         IVrdy,
    output logic [127:0] Dout,
    output logic         Kvld,
    output logic         Dvld,
    output logic         BSY,
    output logic         dbg_state
);

    localparam int NITER = 10 / UNROLL;

    if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 5 || UNROLL == 10)) begin : g_bad_unroll
        $error("aes_composite_enc_unrolled: UNROLL must be 1, 2, 5 or 10");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ ({8{a[7]}} & 8'h1b);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = '0;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = xtime(t);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = gf_inv(x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    // Byte i of the block sits at [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) sr[4*c+w] = sb[4*((c+w)%4)+w];
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) r[127-32*c -: 32] = {a0, a1, a2, a3};
            else      r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r ^ rk;
    endfunction

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] key_q, ctr_q, blk_q, din_q, rkey_q, dout_q;
    logic [7:0]   rcon_q;
    logic [3:0]   cnt_q;
    logic         mode_q, kvld_q, dvld_q;
    logic         busy, cnt_last, k_acc, iv_acc, d_acc;
    logic [127:0] k_use, x_sel, blk_next, rkey_next;
    logic [7:0]   rcon_next;

    assign busy     = (fsm_q == S_RUN);
    assign cnt_last = (cnt_q == 4'(NITER - 1));
    assign k_acc    = EN && !busy && Krdy;
    assign iv_acc   = EN && !busy && IVrdy;
    assign d_acc    = EN && !busy && Drdy;
    // Same-cycle key/counter strobes bypass their registers into the first AddRoundKey.
    assign k_use    = k_acc ? Kin : key_q;
    assign x_sel    = Mode ? (iv_acc ? IVin : ctr_q) : Din;

    for (genvar g = 0; g < UNROLL; g++) begin : g_stage
        logic [127:0] st_i, rk_i, st_o, rk_o;
        logic [7:0]   rc_i, rc_o;
        if (g == 0) begin : g_head
            assign st_i = blk_q;
            assign rk_i = rkey_q;
            assign rc_i = rcon_q;
        end else begin : g_link
            assign st_i = g_stage[g-1].st_o;
            assign rk_i = g_stage[g-1].rk_o;
            assign rc_i = g_stage[g-1].rc_o;
        end
        assign rk_o = key_step(rk_i, rc_i);
        assign rc_o = xtime(rc_i);
        // Round 10 is always the last stage of the last iteration.
        assign st_o = aes_round(st_i, rk_o, (g == UNROLL - 1) && cnt_last);
    end

    assign blk_next  = g_stage[UNROLL-1].st_o;
    assign rkey_next = g_stage[UNROLL-1].rk_o;
    assign rcon_next = g_stage[UNROLL-1].rc_o;

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (d_acc) fsm_d = S_RUN;
            S_RUN:   if (EN && cnt_last) fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) fsm_q <= S_IDLE;
        else       fsm_q <= fsm_d;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            key_q  <= '0;
            ctr_q  <= '0;
            blk_q  <= '0;
            din_q  <= '0;
            rkey_q <= '0;
            dout_q <= '0;
            rcon_q <= 8'h01;
            cnt_q  <= '0;
            mode_q <= 1'b0;
            kvld_q <= 1'b0;
            dvld_q <= 1'b0;
        end else if (EN) begin
            kvld_q <= k_acc;
            dvld_q <= 1'b0;
            if (k_acc)  key_q <= Kin;
            if (iv_acc) ctr_q <= IVin;
            if (d_acc) begin
                blk_q  <= x_sel ^ k_use;
                din_q  <= Din;
                mode_q <= Mode;
                rcon_q <= 8'h01;
                rkey_q <= k_use;
                cnt_q  <= '0;
            end else if (busy) begin
                blk_q  <= blk_next;
                rkey_q <= rkey_next;
                rcon_q <= rcon_next;
                cnt_q  <= cnt_q + 4'd1;
                if (cnt_last) begin
                    dout_q <= mode_q ? (blk_next ^ din_q) : blk_next;
                    dvld_q <= 1'b1;
                    cnt_q  <= '0;
                    if (mode_q) ctr_q[31:0] <= ctr_q[31:0] + 32'd1;
                end
            end
        end
    end

    assign Dout      = dout_q;
    assign Kvld      = kvld_q;
    assign Dvld      = dvld_q;
    assign BSY       = busy;
    assign dbg_state = fsm_q;

endmodule

// File: doc/aes_composite_enc_unrolled.md
AES_COMPOSITE_ENC_UNROLLED -- requirements
Module: aes_composite_enc_unrolled

Interface
REQ-001 Parameter UNROLL, default 1: AES-128 rounds evaluated per clock; legal values 1, 2, 5, 10; any other value SHALL cause an elaboration error.
REQ-002 Derived constant NITER = 10/UNROLL: iteration cycles per block.
REQ-003 CLK  input  1  system clock; all state SHALL update on the rising edge.
REQ-004 RSTn  input  1  reset; asynchronous, active-low.
REQ-005 EN  input  1  global enable; when low, all state SHALL hold.
REQ-006 Kin  input  128  cipher key.
REQ-007 Krdy  input  1  key load strobe.
REQ-008 Din  input  128  plaintext block.
REQ-009 Drdy  input  1  data start strobe.
REQ-010 Mode  input  1  0 = ECB, 1 = CTR; sampled on Drdy acceptance.
REQ-011 IVin  input  128  initial counter block.
REQ-012 IVrdy  input  1  counter load strobe.
REQ-013 Dout  output  128  result: ciphertext in ECB, keystream XOR captured Din in CTR.
REQ-014 Kvld  output  1  key-accepted pulse.
REQ-015 Dvld  output  1  result-valid pulse.
REQ-016 BSY  output  1  block in progress.

Function
REQ-017 Datapath: UNROLL chained round stages plus UNROLL chained key-expansion stages, with rcon advanced by xtime per stage.
- The stage performing round 10 SHALL omit MixColumns.
REQ-018 Idle is defined as BSY=0.
- Krdy, IVrdy and Drdy SHALL be accepted only when idle and EN=1.
- Any of them asserted while BSY=1 SHALL be ignored, with no state change.
REQ-019 Krdy accepted: key register <= Kin, and Kvld SHALL be 1 for exactly the following cycle.
REQ-020 IVrdy accepted: ctr <= IVin.
REQ-021 Drdy accepted at edge t0:
- State register <= X ^ K, where X = Din (ECB) or ctr (CTR) and K = the current key.
- Din captured; Mode captured; rcon <= 8'h01; round key <= K; BSY <= 1.
REQ-022 Krdy and Drdy accepted together SHALL use Kin directly as K (bypass) and also load the key register.
REQ-023 IVrdy and Drdy accepted together in CTR SHALL use IVin as X; ctr then increments from IVin.
REQ-024 At each iteration edge t1..tNITER, the state register SHALL advance UNROLL rounds.
REQ-025 At edge tNITER:
- Dout <= result, Dvld <= 1, BSY <= 0.
- Total latency from the Drdy edge to Dvld high is NITER cycles.
REQ-026 Dvld SHALL be high for exactly one cycle per block.
- Dout SHALL hold its value until the next block completes.
- Intermediate round states SHALL never appear on Dout.
REQ-027 In CTR mode, at edge tNITER: ctr[31:0] <= ctr[31:0] + 1 mod 2^32 (ffffffff wraps to 00000000), ctr[127:32] unchanged.
- In ECB mode, ctr SHALL be unchanged.
REQ-028 A new Drdy SHALL be acceptable on the cycle after Dvld asserts (back-to-back throughput: one block per NITER+1 cycles).
REQ-029 EN low mid-block:
- The iteration count, state, round key and rcon SHALL freeze.
- On EN return, the block SHALL complete with the correct result, and latency is extended by the stalled cycles.
- Dvld and Kvld SHALL hold their values while EN=0.
REQ-030 Mode changes while BSY=1 SHALL have no effect on the block in progress.

Reset
REQ-031 RSTn low SHALL immediately force the following, regardless of CLK or EN:
- Dout=0, Dvld=0, Kvld=0, BSY=0.
- Key, ctr, state and captured Din = 0; rcon=8'h01; iteration counter idle.
REQ-032 Reset asserted mid-block SHALL abort the block with no Dvld.
- The first Drdy after release SHALL start cleanly.

Verification
REQ-033 ECB FIPS-197 test, for each UNROLL in {1, 2, 5, 10}:
- Stimulus: Krdy with Kin=000102030405060708090a0b0c0d0e0f, then Drdy with Din=00112233445566778899aabbccddeeff.
- Response: Dout=69c4e0d86a7b0430d8cdb78070b4c55a with Dvld exactly NITER cycles after the Drdy edge (10 / 5 / 2 / 1).
REQ-034 ECB simultaneous key and data:
- Stimulus: Krdy+Drdy same cycle, Kin=2b7e151628aed2a6abf7158809cf4f3c, Din=6bc1bee22e409f96e93d7e117393172a.
- Response: Dout=3ad77bb40d7a3660a89ecaf32466ef97 and Kvld pulse.
REQ-035 CTR two blocks:
- Stimulus: same key; IVin=f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff; Mode=1.
- Block 1: Din=6bc1bee22e409f96e93d7e117393172a -> Dout=874d6191b620e3261bef6864990db6ce.
- Block 2: Din=ae2d8a571e03ac9c9eb76fac45af8e51 -> Dout=9806f66b7970fdff8617187bb9fffdff.
REQ-036 CTR wrap: IVin low word ffffffff -> after one block ctr low word = 00000000, upper 96 bits unchanged.
REQ-037 Ignored strobes: Drdy/Krdy pulsed while BSY=1 -> in-flight result unchanged, no extra Dvld, no Kvld.
REQ-038 Stall and reset:
- EN low for 3 cycles mid-block -> correct Dout with Dvld at NITER+3.
- RSTn low mid-block -> all outputs 0, no Dvld.
